// File: rtl/tx_multirate_pkg.sv
// Shared types and rate lookup for the multi-rate load-modulation transmitter.
package tx_multirate_pkg;

  // Bit rate selector: ETU length is 128/64/32/16 carrier clocks
  typedef enum logic [1:0] {
    RATE_FC128 = 2'd0,
    RATE_FC64  = 2'd1,
    RATE_FC32  = 2'd2,
    RATE_FC16  = 2'd3
  } rate_t;

  // Frame sequencer states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SOC  = 2'd1,
    ST_DATA = 2'd2,
    ST_EOC  = 2'd3
  } state_t;

  // Carrier clocks per elementary time unit for a given rate
  function automatic logic [7:0] etu_cycles(rate_t rate);
    case (rate)
      RATE_FC128: return 8'd128;
      RATE_FC64:  return 8'd64;
      RATE_FC32:  return 8'd32;
      default:    return 8'd16;
    endcase
  endfunction

endpackage

// File: rtl/tx_multirate_bit_timer.sv
// ETU/half-ETU timing and subcarrier generation for the latched bit rate.
module tx_bit_timer
  import tx_multirate_pkg::*;
#(
  parameter int SC_HALF = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       active,
  input  logic [1:0] rate,
  output logic       first_half,
  output logic       etu_end,
  output logic       sc
);

  localparam int SCW = (SC_HALF > 1) ? $clog2(SC_HALF) : 1;

  logic [7:0]     etu_len;
  logic [6:0]     etu_last;
  logic [6:0]     half_last;
  logic [6:0]     cnt;
  logic [SCW-1:0] sc_cnt;
  logic           sc_low;
  logic           half_end;

  assign etu_len    = etu_cycles(rate_t'(rate));
  assign etu_last   = etu_len[6:0] - 7'd1;
  assign half_last  = etu_len[7:1] - 7'd1;
  assign etu_end    = active && (cnt == etu_last);
  assign half_end   = active && ((cnt == half_last) || (cnt == etu_last));
  assign first_half = (cnt <= half_last);
  assign sc         = active && !sc_low;

  // Position within the current ETU; parked at zero while no frame is running
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (!active || etu_end) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 7'd1;
    end
  end

  // Subcarrier phase, restarted high at every half-ETU boundary
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sc_cnt <= '0;
      sc_low <= 1'b0;
    end else if (!active || half_end) begin
      sc_cnt <= '0;
      sc_low <= 1'b0;
    end else if (sc_cnt == SCW'(SC_HALF - 1)) begin
      sc_cnt <= '0;
      sc_low <= !sc_low;
    end else begin
      sc_cnt <= sc_cnt + SCW'(1);
    end
  end

endmodule

// File: rtl/tx_multirate.sv
// Manchester/subcarrier load-modulation transmitter with selectable bit rate.
module tx_multirate
  import tx_multirate_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int SC_HALF    = 8
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [1:0]                         rate_sel,
  input  logic [DATA_WIDTH-1:0]              data,
  input  logic                               data_valid,
  input  logic                               data_last,
  input  logic [$clog2(DATA_WIDTH+1)-1:0]    data_bits,
  output logic                               data_ready,
  output logic                               tx_out,
  output logic                               busy,
  output logic                               underrun
);

  localparam int BW = $clog2(DATA_WIDTH + 1);

  state_t                state;
  state_t                next_state;
  logic [1:0]            rate_q;
  logic [DATA_WIDTH-1:0] hold_data;
  logic [DATA_WIDTH-1:0] shift;
  logic [BW-1:0]         hold_bits;
  logic [BW-1:0]         cur_bits;
  logic [BW-1:0]         bit_idx;
  logic                  hold_last;
  logic                  hold_full;
  logic                  cur_last;
  logic                  last_seen;
  logic                  ready_en;
  logic                  first_half;
  logic                  etu_end;
  logic                  sc;
  logic                  accept;
  logic                  last_bit;
  logic                  reload;

  tx_bit_timer #(
    .SC_HALF(SC_HALF)
  ) u_timer (
    .clk       (clk),
    .rst       (rst),
    .active    (busy),
    .rate      (rate_q),
    .first_half(first_half),
    .etu_end   (etu_end),
    .sc        (sc)
  );

  assign busy       = (state != ST_IDLE);
  assign last_bit   = (bit_idx == cur_bits - BW'(1));
  assign underrun   = (state == ST_DATA) && etu_end && last_bit && !cur_last && !hold_full;
  assign reload     = etu_end && ((state == ST_SOC) ||
                      ((state == ST_DATA) && last_bit && !cur_last && hold_full));
  assign data_ready = ready_en && !hold_full && !last_seen && (state != ST_EOC) && !underrun;
  assign accept     = data_valid && data_ready;

  // State register; reset abandons any frame without an EOC
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Frame sequencing and Manchester/subcarrier output gating
  always_comb begin
    next_state = state;
    tx_out     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept) next_state = ST_SOC;
      end
      ST_SOC: begin
        tx_out = sc && first_half;
        if (etu_end) next_state = ST_DATA;
      end
      ST_DATA: begin
        tx_out = sc && (shift[0] ? first_half : !first_half);
        if (etu_end && last_bit && (cur_last || !hold_full)) next_state = ST_EOC;
      end
      ST_EOC: begin
        if (etu_end) next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // Holding register, shift register and bit bookkeeping
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ready_en  <= 1'b0;
      rate_q    <= 2'd0;
      hold_data <= '0;
      hold_bits <= '0;
      hold_last <= 1'b0;
      hold_full <= 1'b0;
      shift     <= '0;
      cur_bits  <= '0;
      cur_last  <= 1'b0;
      bit_idx   <= '0;
      last_seen <= 1'b0;
    end else begin
      ready_en <= 1'b1;
      if (accept) begin
        hold_data <= data;
        hold_bits <= data_last ? data_bits : BW'(DATA_WIDTH);
        hold_last <= data_last;
        hold_full <= 1'b1;
        if (data_last) last_seen <= 1'b1;
        if (state == ST_IDLE) rate_q <= rate_sel;
      end
      if (reload) begin
        shift     <= hold_data;
        cur_bits  <= hold_bits;
        cur_last  <= hold_last;
        bit_idx   <= '0;
        hold_full <= 1'b0;
      end else if ((state == ST_DATA) && etu_end) begin
        shift   <= shift >> 1;
        bit_idx <= bit_idx + BW'(1);
      end
      if ((state == ST_EOC) && etu_end) last_seen <= 1'b0;
    end
  end

endmodule

// File: tb/tb_tx_multirate.sv
// Self-checking bench: timing-arithmetic reference model plus directed literal checks.
module tb_tx_multirate;

  localparam int DW      = 8;
  localparam int SC_HALF = 8;

  logic       clk;
  logic       rst;
  logic [1:0] rate_sel;
  logic [7:0] data;
  logic       data_valid;
  logic       data_last;
  logic [3:0] data_bits;
  logic       data_ready;
  logic       tx_out;
  logic       busy;
  logic       underrun;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  int cnt_busy    = 0;
  int cnt_txhi    = 0;
  int cnt_und     = 0;
  int cnt_idle    = 0;

  // Reference model: a frame is a list of bits laid on a time grid of ETUs
  bit m_frame;
  int m_t0;
  int m_e;
  bit m_bits[$];
  int m_words;
  bit m_last;
  int m_nslots;
  bit m_ready_en;

  typedef struct packed {
    logic tx;
    logic busy;
    logic und;
    logic rdy;
  } exp_t;

  tx_multirate #(
    .DATA_WIDTH(DW),
    .SC_HALF   (SC_HALF)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rate_sel  (rate_sel),
    .data      (data),
    .data_valid(data_valid),
    .data_last (data_last),
    .data_bits (data_bits),
    .data_ready(data_ready),
    .tx_out    (tx_out),
    .busy      (busy),
    .underrun  (underrun)
  );

  // Carrier clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Expected load-modulation level for one bit at a given offset into its ETU
  function automatic bit exp_tx(bit b, int off, int e);
    int h;
    bit scv;
    bit fh;
    h   = off % (e / 2);
    scv = ((h / SC_HALF) % 2) == 0;
    fh  = off < (e / 2);
    return scv && (b ? fh : !fh);
  endfunction

  // Expected outputs during cycle c, derived from the frame's time grid
  function automatic exp_t model_expect(int c);
    exp_t r;
    int el;
    int slot;
    int off;
    int loaded;
    r = '0;
    if (!m_frame) begin
      r.rdy = m_ready_en;
      return r;
    end
    el     = c - m_t0;
    slot   = el / m_e;
    off    = el % m_e;
    r.busy = 1'b1;
    if (m_nslots >= 0 && slot >= m_nslots) return r;
    if (slot < m_bits.size()) r.tx = exp_tx(m_bits[slot], off, m_e);
    r.und  = !m_last && (slot == DW * m_words) && (off == m_e - 1);
    loaded = (slot == 0) ? 0 : ((slot - 1) / DW + 1);
    if (loaded > m_words) loaded = m_words;
    r.rdy  = m_ready_en && !m_last && (loaded == m_words) && !r.und;
    return r;
  endfunction

  task automatic model_append();
    int n;
    n = data_last ? int'(data_bits) : DW;
    for (int i = 0; i < n; i++) m_bits.push_back(data[i]);
    m_words++;
    if (data_last) begin
      m_last   = 1'b1;
      m_nslots = m_bits.size();
    end
  endtask

  task automatic model_step();
    exp_t e;
    int el;
    int slot;
    int off;
    e = model_expect(cyc);
    if (!m_frame) begin
      if (data_valid && e.rdy) begin
        m_frame  = 1'b1;
        m_t0     = cyc + 1;
        m_e      = 128 >> rate_sel;
        m_bits.delete();
        m_bits.push_back(1'b1);
        m_words  = 0;
        m_last   = 1'b0;
        m_nslots = -1;
        model_append();
      end
    end else begin
      el   = cyc - m_t0;
      slot = el / m_e;
      off  = el % m_e;
      if (data_valid && e.rdy) model_append();
      if (e.und) m_nslots = slot + 1;
      if (m_nslots >= 0 && slot == m_nslots && off == m_e - 1) m_frame = 1'b0;
    end
    m_ready_en = 1'b1;
    cyc++;
  endtask

  // Model advance on every active edge; reset clears it immediately
  initial begin
    m_frame    = 1'b0;
    m_ready_en = 1'b0;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_frame    = 1'b0;
        m_ready_en = 1'b0;
      end else begin
        model_step();
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
    vectors++;
    if (actual !== required) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, required, cyc);
    end
  endtask

  // Per-cycle comparison against the model, plus activity counters
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      e = model_expect(cyc);
      checkOutput("tx_out", tx_out, e.tx);
      checkOutput("busy", busy, e.busy);
      checkOutput("underrun", underrun, e.und);
      checkOutput("data_ready", data_ready, e.rdy);
      if (busy === 1'b1) cnt_busy++;
      else cnt_idle++;
      if (tx_out === 1'b1) cnt_txhi++;
      if (underrun === 1'b1) cnt_und++;
    end
  end

  task automatic applyStimulus(input logic v, input logic [7:0] d, input logic l,
                               input logic [3:0] b, input logic [1:0] r);
    data_valid = v;
    data       = d;
    data_last  = l;
    data_bits  = b;
    rate_sel   = r;
  endtask

  task automatic clear_counts();
    cnt_busy = 0;
    cnt_txhi = 0;
    cnt_und  = 0;
    cnt_idle = 0;
  endtask

  // Offer a word until the handshake completes; returns just after the accepting edge
  task automatic send_word(input logic [7:0] d, input logic l, input logic [3:0] b, input logic [1:0] r);
    int  n;
    bit  rdy;
    n = 0;
    applyStimulus(1'b1, d, l, b, r);
    forever begin
      @(negedge clk);
      rdy = (data_ready === 1'b1);
      @(posedge clk);
      #1;
      n++;
      if (rdy) break;
      if (n >= 4000) begin
        vectors++;
        miscompares++;
        $display("[TB] FAIL send_word: no acceptance after %0d cycles, expected within 4000", n);
        break;
      end
    end
    data_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while ((busy !== 1'b0 || m_frame) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (n >= budget) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL wait_idle: still busy after %0d cycles, expected idle", n);
    end
    @(posedge clk);
    #1;
  endtask

  // Watchdog so the run always terminates
  initial begin
    #3000000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed scenarios followed by randomized frames
  initial begin
    int nw;
    int gap;
    int e;
    logic [1:0] r;
    rst = 1'b1;
    applyStimulus(1'b0, 8'h00, 1'b0, 4'd0, 2'd0);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_tx_out", tx_out, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_underrun", underrun, 0);
    checkOutput("rst_data_ready", data_ready, 0);

    checkOutput("model_one_first", exp_tx(1'b1, 0, 16), 1);
    checkOutput("model_one_second", exp_tx(1'b1, 8, 16), 0);
    checkOutput("model_zero_second", exp_tx(1'b0, 8, 16), 1);
    checkOutput("model_zero_first", exp_tx(1'b0, 0, 16), 0);
    checkOutput("model_sc_low_128", exp_tx(1'b1, 8, 128), 0);
    checkOutput("model_sc_high_128", exp_tx(1'b1, 16, 128), 1);
    checkOutput("model_zero_half_128", exp_tx(1'b0, 64, 128), 1);
    checkOutput("model_zero_sc_low_128", exp_tx(1'b0, 72, 128), 0);

    @(negedge clk);
    #2 rst = 1'b0;
    #1 checkOutput("ready_before_edge", data_ready, 0);
    @(posedge clk);
    #1 checkOutput("ready_after_edge", data_ready, 1);

    // Two full bytes at fc/16
    clear_counts();
    send_word(8'hA5, 1'b0, 4'd0, 2'd3);
    checkOutput("first_mod_cycle", tx_out, 1);
    checkOutput("first_busy_cycle", busy, 1);
    send_word(8'h3C, 1'b1, 4'd8, 2'd3);
    wait_idle(2000);
    checkOutput("a53c_busy_cycles", cnt_busy, 288);
    checkOutput("a53c_tx_high", cnt_txhi, 136);
    checkOutput("a53c_underruns", cnt_und, 0);

    // Short final word: SOC + 3 bits + EOC
    clear_counts();
    send_word(8'h05, 1'b1, 4'd3, 2'd3);
    wait_idle(2000);
    checkOutput("short_busy_cycles", cnt_busy, 80);
    checkOutput("short_tx_high", cnt_txhi, 32);

    // Starved frame: one word then nothing
    clear_counts();
    send_word(8'hFF, 1'b0, 4'd0, 2'd3);
    wait_idle(2000);
    checkOutput("starve_busy_cycles", cnt_busy, 160);
    checkOutput("starve_underruns", cnt_und, 1);
    checkOutput("starve_tx_high", cnt_txhi, 72);

    // Rate change mid-frame only affects the next frame
    clear_counts();
    send_word(8'h02, 1'b1, 4'd2, 2'd0);
    rate_sel = 2'd2;
    wait_idle(2000);
    checkOutput("slow_busy_cycles", cnt_busy, 512);
    checkOutput("slow_tx_high", cnt_txhi, 96);
    clear_counts();
    send_word(8'h02, 1'b1, 4'd2, 2'd2);
    wait_idle(2000);
    checkOutput("fast_busy_cycles", cnt_busy, 128);
    checkOutput("fast_tx_high", cnt_txhi, 24);

    // Back-to-back: next word offered during EOC starts after one idle cycle
    send_word(8'h01, 1'b1, 4'd1, 2'd3);
    clear_counts();
    send_word(8'h00, 1'b1, 4'd1, 2'd3);
    checkOutput("b2b_idle_cycles", cnt_idle, 1);
    checkOutput("b2b_busy_cycles", cnt_busy, 48);
    wait_idle(2000);

    // Reset mid-bit, then a long quiet stretch
    send_word(8'hC3, 1'b0, 4'd0, 2'd1);
    repeat (40) @(posedge clk);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checkOutput("midrst_tx_out", tx_out, 0);
    checkOutput("midrst_busy", busy, 0);
    checkOutput("midrst_data_ready", data_ready, 0);
    checkOutput("midrst_underrun", underrun, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    #2 rst = 1'b0;
    @(posedge clk);
    #1;
    clear_counts();
    repeat (512) @(posedge clk);
    #1;
    checkOutput("quiet_tx_high", cnt_txhi, 0);
    checkOutput("quiet_busy", cnt_busy, 0);

    // Randomized frames with random gaps and mid-frame rate noise
    for (int f = 0; f < 12; f++) begin
      nw = $urandom_range(1, 3);
      r  = 2'($urandom_range(0, 3));
      e  = 128 >> r;
      for (int w = 0; w < nw; w++) begin
        gap = ($urandom_range(0, 6) == 0) ? $urandom_range(0, 9 * e) : $urandom_range(0, 3);
        repeat (gap) begin
          @(posedge clk);
          #1;
        end
        send_word(8'($urandom), (w == nw - 1), 4'($urandom_range(1, 8)),
                  (w == 0) ? r : 2'($urandom_range(0, 3)));
      end
      wait_idle(3000);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
